// File: rtl/countdown_pkg.sv
// Shared encodings and defaults for the seconds countdown controller.
// The divider-width helper keeps a one-cycle divide from collapsing to a zero-width register.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int CW_DEFAULT   = 5;
  localparam int TICK_DIV_HW  = 100000000;
  localparam int TICK_DIV_SIM = 4;

  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Turns a debounced button level into a single-cycle press event.
// History resets to 1 so a button held through reset never produces a press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_press
);

  logic r_hist;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_hist <= 1'b1;
    else     r_hist <= i_level;
  end

  assign o_press = i_level & ~r_hist;

endmodule

// File: rtl/countdown_ctrl.sv
// Run/pause/expired sequencer owning the 1 Hz divider and the remaining-seconds register.
// Every output is registered; tick and done are one-cycle strobes.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_HW,
  parameter int CW       = CW_DEFAULT
) (
  input  logic          clock_out,
  input  logic          reset,
  input  logic          btn_start,
  input  logic          btn_pause,
  input  logic          btn_restart,
  input  logic [CW-1:0] preset,
  output logic [CW-1:0] count,
  output logic [1:0]    state,
  output logic          tick,
  output logic          done,
  output logic          alarm
);

  localparam int            DW       = div_width(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic          w_start;
  logic          w_pause;
  logic          w_restart;
  logic          w_div_last;
  logic [DW-1:0] r_div;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic          r_tick;
  logic          r_done;
  logic          r_alarm;

  btn_edge u_start   (.clk(clock_out), .rst(reset), .i_level(btn_start),   .o_press(w_start));
  btn_edge u_pause   (.clk(clock_out), .rst(reset), .i_level(btn_pause),   .o_press(w_pause));
  btn_edge u_restart (.clk(clock_out), .rst(reset), .i_level(btn_restart), .o_press(w_restart));

  assign w_div_last = (r_div == DIV_LAST);

  always_ff @(posedge clock_out) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_div   <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      if (w_restart) begin
        // Restart outranks everything, including a tick due this cycle.
        r_state <= ST_IDLE;
        r_div   <= '0;
        r_count <= preset;
        r_alarm <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_count <= preset;
            if (w_start) begin
              if (preset != '0) begin
                r_state <= ST_RUN;
                r_div   <= '0;
              end else begin
                r_state <= ST_EXPIRED;
                r_done  <= 1'b1;
                r_alarm <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (w_div_last) begin
              r_div  <= '0;
              r_tick <= 1'b1;
              if (r_count != '0) r_count <= r_count - 1'b1;
            end else begin
              r_div <= r_div + 1'b1;
            end
            // Expiry beats a same-cycle pause; otherwise pause keeps the decremented count.
            if (w_div_last && r_count == CW'(1)) begin
              r_state <= ST_EXPIRED;
              r_done  <= 1'b1;
              r_alarm <= 1'b1;
            end else if (w_pause) begin
              r_state <= ST_PAUSE;
            end
          end
          ST_PAUSE: begin
            if (w_start) r_state <= ST_RUN;
          end
          ST_EXPIRED: begin
            r_count <= '0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign count = r_count;
  assign state = r_state;
  assign tick  = r_tick;
  assign done  = r_done;
  assign alarm = r_alarm;

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Sequencing controller for the seconds countdown datapath.
- Turns start/pause/restart button levels into single-cycle press events.
- Generates the 1 Hz decrement tick from the system clock.
- Owns the remaining-seconds register and the run/pause/expired state machine.
- Drives the display value and the alarm/done indicators. Sits between the debounced board buttons and the 7-seg/LED output logic.

Parameters:
- TICK_DIV, 100000000, clock cycles per countdown second (4 in simulation).
- CW, 5, width of seconds preset and remaining count.

Ports:
- clock_out  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; returns block to initial state.
- btn_start  input  1  debounced level, synchronous to clock_out.
- btn_pause  input  1  debounced level.
- btn_restart  input  1  debounced level.
- preset  input  CW  countdown start value in seconds.
- count  output  CW  remaining seconds (registered).
- state  output  2  current state: 0 IDLE, 1 RUN, 2 PAUSE, 3 EXPIRED.
- tick  output  1  one-cycle strobe on each accepted decrement.
- done  output  1  one-cycle strobe on entry to EXPIRED.
- alarm  output  1  level, high while in EXPIRED.

Behaviour:
- Reset (sync, active-high): state=IDLE, count=0, divider=0, tick=0, done=0, alarm=0, edge-detect history=1. A button held through reset therefore produces no press.
- Press event: level=1 this cycle and level=0 in the previous cycle. Holding a button gives exactly one event.
- Event priority in one cycle: restart > pause > start.
- State transitions:
  - restart in any state: go to IDLE, divider=0.
  - IDLE: count <= preset every cycle (one-cycle lag).
    - start with preset!=0: go to RUN, count <= preset, divider=0.
    - start with preset==0: go to EXPIRED, done=1.
    - pause: ignored.
  - RUN:
    - divider counts 0..TICK_DIV-1 and wraps.
    - At divider==TICK_DIV-1: tick=1 and count <= count-1.
    - If count==1 at that tick: go to EXPIRED, done=1.
    - pause: go to PAUSE.
    - start: ignored.
  - PAUSE: divider and count frozen; no ticks. start resumes RUN with the divider continuing from its held value, so the fractional second is preserved. pause is ignored.
  - EXPIRED: count=0, alarm=1. start and pause are ignored; only restart or reset leaves.
- Pause and terminal tick in the same cycle: the decrement is applied; expiry wins (EXPIRED, done=1). Otherwise pause wins the state (PAUSE with the decremented count).
- Restart and tick in the same cycle: restart wins; no tick and no decrement.
- preset is sampled only in IDLE and on start from IDLE. Changes in RUN/PAUSE/EXPIRED are ignored.
- Arithmetic: count never decrements below 0 and never wraps. divider width is clog2(TICK_DIV).
- Outputs are registered; tick and done assert in the cycle after the causing edge.
- alarm = (state==EXPIRED).

Decomposition:
- Package countdown_pkg holds:
  - state encoding constants ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_EXPIRED=3;
  - CW default;
  - the TICK_DIV simulation value.
- One sub-module, btn_edge (register plus rising-edge detect, reset history=1), instantiated three times.
- Divider, count register and FSM stay in countdown_ctrl.

Test Plan:
- Basic run: TICK_DIV=4, preset=3, reset, press start → state=1, count 3→2→1→0 at 4-cycle intervals. done pulses once with the last tick, then state=3, alarm=1.
- Pause/resume: preset=5, start, pause 2 cycles into the second → count holds at 4 for 20 cycles, no tick. start → next tick exactly 2 cycles later, count=3.
- Held/simultaneous buttons: hold btn_start 30 cycles → only one start event. Assert pause+start together in RUN → PAUSE.
- Zero preset: preset=0, start → state=3, done=1 within 1 cycle, count=0. start and pause are then ignored; restart → IDLE, count=preset.
- Restart mid-run: preset=7, run to count=4, restart in a tick cycle → IDLE, count=7, tick=0. Change preset to 9 → count=9 one cycle later.
- Reset mid-operation: in PAUSE with count=2 assert reset 1 cycle while btn_start is held → state=0, count=0, alarm=0. No start event until the button is released and pressed again.
